// File: rtl/oled_select_grid.sv
// Row of NUM_SQ colour squares with a movable green selection border on the 96x64 OLED.
// Also owns button sync/edge detection, cursor movement, colour cycling and post-action lockout.
module oled_select_grid #(
  parameter int NUM_SQ   = 5,
  parameter int PERIOD   = 18,
  parameter int X0       = 9,
  parameter int Y0       = 29,
  parameter int SQ_SIZE  = 6,
  parameter int GAP      = 1,
  parameter int BW       = 3,
  parameter int TICK_DIV = 100000,
  parameter int LOCK_MS  = 200,
  parameter int WRAP     = 0,
  parameter int PER_SQ   = 1
) (
  input  logic        clk,
  input  logic        notReset,
  input  logic [12:0] pixel_index,
  input  logic        enable,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        btnC,
  output logic [15:0] oled_data,
  output logic [2:0]  cursor_pos,
  output logic        busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = $clog2(LOCK_MS + 1);
  localparam logic [2:0]  LAST    = 3'(NUM_SQ - 1);
  localparam logic [8:0]  C_Y0    = 9'(Y0);
  localparam logic [8:0]  C_SQ    = 9'(SQ_SIZE);
  localparam logic [8:0]  C_SQM1  = 9'(SQ_SIZE - 1);
  localparam logic [8:0]  C_G     = 9'(GAP);
  localparam logic [8:0]  C_GB    = 9'(GAP + BW);
  localparam logic [15:0] GREEN   = 16'h07E0;

  typedef enum logic {ST_INTRO = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic            w_active;
  logic [TW-1:0]   r_tick;
  logic            w_tick;
  logic [2:0]      r_sync1, r_sync2, r_btn_d;
  logic [2:0]      w_edge;
  logic            w_do_l, w_do_r, w_do_c, w_accept;
  logic [2:0]      r_cursor;
  logic [NUM_SQ-1:0][1:0] r_col;
  logic            r_busy;
  logic [LW-1:0]   r_lock;
  logic [8:0]      w_x, w_y;
  logic            w_in_sq, w_ring_cur, w_ring_mid;
  logic [1:0]      w_sq_col;
  logic [15:0]     w_pix, r_oled;

  function automatic logic [8:0] sq_x(input int i);
    return 9'(X0 + i * PERIOD);
  endfunction

  function automatic logic [15:0] palette(input logic [1:0] c);
    case (c)
      2'd0:    return 16'hFFFF;
      2'd1:    return 16'hF800;
      2'd2:    return 16'h07E0;
      2'd3:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic in_square(input logic [8:0] x, input logic [8:0] y, input logic [8:0] sx);
    return (x >= sx) && (x < sx + C_SQ) && (y >= C_Y0) && (y < C_Y0 + C_SQ);
  endfunction

  // Ring = outer box minus inner box; offsets are added to x/y so nothing goes negative.
  function automatic logic ring_hit(input logic [8:0] x, input logic [8:0] y, input logic [8:0] sx);
    logic outer, inner;
    outer = (x + C_GB >= sx) && (x <= sx + C_SQM1 + C_GB) &&
            (y + C_GB >= C_Y0) && (y <= C_Y0 + C_SQM1 + C_GB);
    inner = (x + C_G >= sx) && (x <= sx + C_SQM1 + C_G) &&
            (y + C_G >= C_Y0) && (y <= C_Y0 + C_SQM1 + C_G);
    return outer && !inner;
  endfunction

  // Mode state register
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) r_state <= ST_INTRO;
    else           r_state <= w_state_nxt;
  end

  // Mode next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INTRO:  w_state_nxt = enable ? ST_ACTIVE : ST_INTRO;
      ST_ACTIVE: w_state_nxt = enable ? ST_ACTIVE : ST_INTRO;
      default:   w_state_nxt = ST_INTRO;
    endcase
  end

  // Mode output decode
  always_comb begin
    w_active = 1'b0;
    case (r_state)
      ST_ACTIVE: w_active = 1'b1;
      default:   w_active = 1'b0;
    endcase
  end

  assign w_tick = (r_tick == TW'(TICK_DIV - 1));

  // Free-running millisecond tick counter
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset)   r_tick <= '0;
    else if (w_tick) r_tick <= '0;
    else             r_tick <= r_tick + 1'b1;
  end

  // Two-flop synchroniser plus delayed copy for rising-edge detect, bits {C,R,L}
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_btn_d <= 3'b000;
    end else begin
      r_sync1 <= {btnC, btnR, btnL};
      r_sync2 <= r_sync1;
      r_btn_d <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_btn_d;

  // Action arbitration: L beats R beats C; a saturated move is rejected without lockout
  always_comb begin
    w_do_l = 1'b0;
    w_do_r = 1'b0;
    w_do_c = 1'b0;
    if (w_active && !r_busy) begin
      if (w_edge[0])      w_do_l = (r_cursor != 3'd0) || (WRAP != 0);
      else if (w_edge[1]) w_do_r = (r_cursor != LAST) || (WRAP != 0);
      else if (w_edge[2]) w_do_c = 1'b1;
      else                w_do_c = 1'b0;
    end else begin
      w_do_l = 1'b0;
    end
  end

  assign w_accept = w_do_l | w_do_r | w_do_c;

  // Cursor register
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset)   r_cursor <= LAST;
    else if (w_do_l) r_cursor <= (r_cursor == 3'd0) ? LAST : r_cursor - 3'd1;
    else if (w_do_r) r_cursor <= (r_cursor == LAST) ? 3'd0 : r_cursor + 3'd1;
  end

  // Colour index registers
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      r_col <= '0;
    end else begin
      for (int i = 0; i < NUM_SQ; i++) begin
        if (w_do_c && ((PER_SQ == 0) || (r_cursor == 3'(i)))) r_col[i] <= r_col[i] + 2'd1;
      end
    end
  end

  // Lockout: counts LOCK_MS ticks after an accepted action
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      r_busy <= 1'b0;
      r_lock <= '0;
    end else if (w_accept) begin
      r_busy <= 1'b1;
      r_lock <= '0;
    end else if (r_busy && w_tick) begin
      if (r_lock == LW'(LOCK_MS - 1)) begin
        r_busy <= 1'b0;
        r_lock <= '0;
      end else begin
        r_lock <= r_lock + 1'b1;
      end
    end
  end

  assign w_x = 9'(pixel_index % 13'd96);
  assign w_y = 9'(pixel_index / 13'd96);

  // Geometry hit tests for the current pixel
  always_comb begin
    w_in_sq    = 1'b0;
    w_sq_col   = 2'd0;
    w_ring_cur = 1'b0;
    for (int i = 0; i < NUM_SQ; i++) begin
      if (in_square(w_x, w_y, sq_x(i))) begin
        w_in_sq  = 1'b1;
        w_sq_col = r_col[i];
      end
      if (r_cursor == 3'(i)) w_ring_cur = ring_hit(w_x, w_y, sq_x(i));
    end
    w_ring_mid = ring_hit(w_x, w_y, sq_x(NUM_SQ / 2));
  end

  // Pixel colour selection
  always_comb begin
    w_pix = 16'h0000;
    if (pixel_index >= 13'd6144) w_pix = 16'h0000;
    else if (!w_active)          w_pix = w_ring_mid ? GREEN : 16'h0000;
    else if (w_in_sq)            w_pix = palette(w_sq_col);
    else if (w_ring_cur)         w_pix = GREEN;
    else                         w_pix = 16'h0000;
  end

  // Registered pixel output
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) r_oled <= 16'h0000;
    else           r_oled <= w_pix;
  end

  assign oled_data  = r_oled;
  assign cursor_pos = r_cursor;
  assign busy       = r_busy;

endmodule

// File: tb/tb_oled_select_grid.sv
// Bench for oled_select_grid: two instances (saturating/per-square and wrapping/global) driven
// identically and checked every cycle against a geometric reference model, plus literal spot checks.
module tb_oled_select_grid;
  localparam int TD = 20, LM = 10, NSQ = 5, PER = 18, X0 = 9, Y0 = 29, SQ = 6, GAP = 1, BW = 3;

  logic        clk = 1'b0;
  logic        notReset, enable, btnL, btnR, btnC;
  logic [12:0] pixel_index;
  logic [15:0] oled0, oled1;
  logic [2:0]  cur0, cur1;
  logic        busy0, busy1;
  int checks = 0, failures = 0;
  bit rnd_pix = 1'b0;

  always #5 clk = ~clk;

  oled_select_grid #(.TICK_DIV(TD), .LOCK_MS(LM), .WRAP(0), .PER_SQ(1)) u0 (
    .clk(clk), .notReset(notReset), .pixel_index(pixel_index), .enable(enable),
    .btnL(btnL), .btnR(btnR), .btnC(btnC), .oled_data(oled0), .cursor_pos(cur0), .busy(busy0));

  oled_select_grid #(.TICK_DIV(TD), .LOCK_MS(LM), .WRAP(1), .PER_SQ(0)) u1 (
    .clk(clk), .notReset(notReset), .pixel_index(pixel_index), .enable(enable),
    .btnL(btnL), .btnR(btnR), .btnC(btnC), .oled_data(oled1), .cursor_pos(cur1), .busy(busy1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_cur[2], m_busy[2], m_lcnt[2];
  int          m_col[2][NSQ];
  logic [15:0] m_exp[2];
  int          m_mode, m_tcnt;
  bit          hist[3][3];   // hist[button][k]: raw value sampled k+1 edges ago

  function automatic logic [15:0] pal(input int c);
    case (c)
      0:       return 16'hFFFF;
      1:       return 16'hF800;
      2:       return 16'h07E0;
      3:       return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic bit in_box(input int x, input int y, input int x0, input int x1, input int y0, input int y1);
    return x >= x0 && x <= x1 && y >= y0 && y <= y1;
  endfunction

  function automatic logic [15:0] model_pix(input int d, input int idx);
    int x, y, sx, sel;
    if (idx >= 96 * 64) return 16'h0000;
    x = idx % 96;
    y = idx / 96;
    if (m_mode != 0)
      for (int i = 0; i < NSQ; i++) begin
        sx = X0 + i * PER;
        if (in_box(x, y, sx, sx + SQ - 1, Y0, Y0 + SQ - 1)) return pal(m_col[d][i]);
      end
    sel = (m_mode != 0) ? m_cur[d] : NSQ / 2;
    sx  = X0 + sel * PER;
    if (in_box(x, y, sx - GAP - BW, sx + SQ - 1 + GAP + BW, Y0 - GAP - BW, Y0 + SQ - 1 + GAP + BW) &&
        !in_box(x, y, sx - GAP, sx + SQ - 1 + GAP, Y0 - GAP, Y0 + SQ - 1 + GAP))
      return 16'h07E0;
    return 16'h0000;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cur[d] = NSQ - 1; m_busy[d] = 0; m_lcnt[d] = 0; m_exp[d] = 16'h0000;
      for (int i = 0; i < NSQ; i++) m_col[d][i] = 0;
    end
    m_mode = 0; m_tcnt = 0;
    for (int b = 0; b < 3; b++) for (int k = 0; k < 3; k++) hist[b][k] = 1'b0;
  endtask

  task automatic model_step();
    bit tick, acc;
    bit ed[3];
    bit raw[3];
    raw[0] = btnL; raw[1] = btnR; raw[2] = btnC;
    tick = (m_tcnt == TD - 1);
    // A button press is acted on two clocks after it is first sampled.
    for (int b = 0; b < 3; b++) ed[b] = hist[b][1] && !hist[b][2];
    for (int d = 0; d < 2; d++) begin
      m_exp[d] = model_pix(d, int'(pixel_index));
      acc = 1'b0;
      if (m_mode != 0 && m_busy[d] == 0) begin
        if (ed[0]) begin
          if (m_cur[d] > 0) begin m_cur[d]--; acc = 1'b1; end
          else if (d == 1) begin m_cur[d] = NSQ - 1; acc = 1'b1; end
        end else if (ed[1]) begin
          if (m_cur[d] < NSQ - 1) begin m_cur[d]++; acc = 1'b1; end
          else if (d == 1) begin m_cur[d] = 0; acc = 1'b1; end
        end else if (ed[2]) begin
          acc = 1'b1;
          for (int i = 0; i < NSQ; i++)
            if (d == 1 || i == m_cur[d]) m_col[d][i] = (m_col[d][i] + 1) % 4;
        end
      end
      if (m_busy[d] != 0) begin
        if (tick) begin
          m_lcnt[d]++;
          if (m_lcnt[d] == LM) m_busy[d] = 0;
        end
      end else if (acc) begin
        m_busy[d] = 1;
        m_lcnt[d] = 0;
      end
    end
    for (int b = 0; b < 3; b++) begin
      hist[b][2] = hist[b][1];
      hist[b][1] = hist[b][0];
      hist[b][0] = raw[b];
    end
    m_mode = enable ? 1 : 0;
    m_tcnt = (m_tcnt + 1) % TD;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge notReset);
      if (!notReset) model_reset();
      else           model_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      check("oled0", oled0, m_exp[0]);
      check("oled1", oled1, m_exp[1]);
      check("cursor0", cur0, m_cur[0]);
      check("cursor1", cur1, m_cur[1]);
      check("busy0", busy0, m_busy[0]);
      check("busy1", busy1, m_busy[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rnd_pix) begin
        if ($urandom_range(0, 3) == 0) pixel_index = 13'($urandom_range(0, 8191));
        else pixel_index = 13'($urandom_range(20, 42) * 96 + $urandom_range(0, 95));
      end
    end
  endtask

  task automatic press(input bit l, input bit r, input bit c);
    btnL = l; btnR = r; btnC = c;
    cyc(3);
    btnL = 1'b0; btnR = 1'b0; btnC = 1'b0;
  endtask

  task automatic show_pix(input int idx);
    pixel_index = 13'(idx);
    cyc(1);
  endtask

  initial begin
    notReset = 1'b0; enable = 1'b0; btnL = 1'b0; btnR = 1'b0; btnC = 1'b0; pixel_index = 13'd0;
    cyc(3);
    check("rst_cursor", cur0, 3'd4);
    check("rst_busy", busy0, 1'b0);
    check("rst_oled", oled0, 16'h0000);
    notReset = 1'b1;

    for (int i = 0; i < 6144; i++) begin
      pixel_index = 13'(i);
      cyc(1);
    end
    show_pix(29 * 96 + 41); check("intro_ring_l", oled0, 16'h07E0);
    show_pix(25 * 96 + 54); check("intro_ring_tr", oled1, 16'h07E0);
    show_pix(29 * 96 + 45); check("intro_no_sq", oled0, 16'h0000);
    show_pix(24 * 96 + 41); check("intro_outside", oled0, 16'h0000);

    enable = 1'b1;
    cyc(2);
    for (int k = 0; k < 3; k++) begin
      press(1'b1, 1'b0, 1'b0);
      cyc(4);
      check("lock_busy", busy0, 1'b1);
      cyc(240);
      check("left_cursor", cur0, 3'(3 - k));
      check("lock_clear", busy0, 1'b0);
    end
    show_pix(25 * 96 + 23); check("ring_sq1", oled0, 16'h07E0);
    show_pix(29 * 96 + 27); check("sq1_white", oled0, 16'hFFFF);

    press(1'b1, 1'b0, 1'b0); cyc(250);
    press(1'b1, 1'b0, 1'b0); cyc(5);
    check("sat_cursor", cur0, 3'd0);
    check("sat_busy", busy0, 1'b0);
    check("wrap_cursor", cur1, 3'd4);
    check("wrap_busy", busy1, 1'b1);
    cyc(250);

    repeat (4) begin press(1'b0, 1'b1, 1'b0); cyc(250); end
    check("right_cursor0", cur0, 3'd4);
    check("right_cursor1", cur1, 3'd3);
    repeat (2) begin press(1'b0, 1'b0, 1'b1); cyc(250); end
    show_pix(29 * 96 + 81); check("persq_sq4", oled0, 16'h07E0); check("glob_sq4", oled1, 16'h07E0);
    show_pix(29 * 96 + 9);  check("persq_sq0", oled0, 16'hFFFF); check("glob_sq0", oled1, 16'h07E0);

    press(1'b1, 1'b0, 1'b1);
    cyc(60);
    press(1'b1, 1'b0, 1'b0);
    cyc(250);
    check("lc_cursor0", cur0, 3'd3);
    check("lc_cursor1", cur1, 3'd2);
    show_pix(29 * 96 + 81); check("lc_sq4_kept", oled0, 16'h07E0);
    show_pix(29 * 96 + 63); check("lc_sq3_white", oled0, 16'hFFFF);

    rnd_pix = 1'b1;
    repeat (120) begin
      case ($urandom_range(0, 9))
        0:       press(1'b1, 1'b0, 1'b0);
        1:       press(1'b0, 1'b1, 1'b0);
        2:       press(1'b0, 1'b0, 1'b1);
        3:       enable = ~enable;
        default: ;
      endcase
      cyc($urandom_range(1, 300));
    end
    rnd_pix = 1'b0;

    enable = 1'b1;
    cyc(250);
    pixel_index = 13'(29 * 96 + 81);
    press(1'b0, 1'b0, 1'b1);
    cyc(20);
    check("pre_rst_busy", busy0, 1'b1);
    #2 notReset = 1'b0;
    #1;
    check("mid_rst_busy0", busy0, 1'b0);
    check("mid_rst_busy1", busy1, 1'b0);
    check("mid_rst_cursor0", cur0, 3'd4);
    check("mid_rst_cursor1", cur1, 3'd4);
    check("mid_rst_oled", oled0, 16'h0000);
    cyc(2);
    #2 notReset = 1'b1;
    cyc(3);
    show_pix(29 * 96 + 81);
    check("post_rst_white0", oled0, 16'hFFFF);
    check("post_rst_white1", oled1, 16'hFFFF);
    check("post_rst_busy", busy0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
